// File: rtl/enum_op_pkg.sv
// Shared definitions for the enum-opcode issuer/executor pair.
//   op_t    : opcode values understood by the executor (any other value selects MUL)
//   state_t : issuer FSM states
//   op_ref  : reference model of the executor (A = opcode, B = operand), used by the bench
package enum_op_pkg;

    localparam int unsigned NBITS_DEF = 8;

    typedef enum logic [7:0] {
        OP_INC = 8'd17,
        OP_ADD = 8'd18,
        OP_SUB = 8'd19,
        OP_MUL = 8'd20
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Executor behaviour; unknown opcodes fall through to a truncated multiply.
    function automatic logic [7:0] op_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = a * b;
        case (a)
            OP_INC:  return a + 8'd1;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return prod[7:0];
        endcase
    endfunction

endpackage

// File: rtl/enum_op_issuer_if.sv
// Bus between a request producer / executor and the issuer.
//   in_*  : request handshake (valid/ready) with opcode and operand
//   ex_*  : registered operands to the combinational executor and its result
//   out_* : result handshake (valid/ready) with the producing opcode
// master = producer/consumer/executor side, slave = issuer side.
interface enum_op_issuer_if #(
    parameter int unsigned NBITS = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_op;
    logic [NBITS-1:0] in_arg;
    logic [NBITS-1:0] ex_a;
    logic [NBITS-1:0] ex_b;
    logic [NBITS-1:0] ex_xout;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_op;
    logic [NBITS-1:0] out_data;

    modport master (
        output in_valid, in_op, in_arg, ex_xout, out_ready,
        input  in_ready, ex_a, ex_b, out_valid, out_op, out_data
    );

    modport slave (
        input  in_valid, in_op, in_arg, ex_xout, out_ready,
        output in_ready, ex_a, ex_b, out_valid, out_op, out_data
    );
endinterface

// File: rtl/enum_op_fifo.sv
// Request FIFO holding {op, arg} pairs.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   push, push_op/arg   : write request (ignored when full)
//   pop, head_op/arg    : read request (ignored when empty) and current head entry
//   full, empty, count  : occupancy status
module enum_op_fifo #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [NBITS-1:0]         push_op,
    input  logic [NBITS-1:0]         push_arg,
    input  logic                     pop,
    output logic [NBITS-1:0]         head_op,
    output logic [NBITS-1:0]         head_arg,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [2*NBITS-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW:0]        count_q;
    logic               do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign {head_op, head_arg} = mem[rd_ptr_q];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable while count says valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr_q] <= {push_op, push_arg};
    end

endmodule

// File: rtl/enum_op_issuer.sv
// Buffers opcode/operand requests, issues them one at a time to a combinational
// executor, registers the result and presents it with a valid/ready handshake.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : enum_op_issuer_if slave (request in, executor A/B/XOUT, result out)
module enum_op_issuer
    import enum_op_pkg::*;
#(
    parameter int unsigned NBITS = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    enum_op_issuer_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_HOLD  = HOLD;

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] ex_a_q, ex_b_q;
    logic [NBITS-1:0] out_op_q, out_data_q;
    logic             out_valid_q;

    logic             fifo_full, fifo_empty, push, pop;
    logic [CW-1:0]    fifo_count;
    logic [NBITS-1:0] head_op, head_arg;

    assign bus.in_ready = (fifo_count < CW'(DEPTH));
    assign push         = bus.in_valid && !fifo_full;

    enum_op_fifo #(
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (push),
        .push_op  (bus.in_op),
        .push_arg (bus.in_arg),
        .pop      (pop),
        .head_op  (head_op),
        .head_arg (head_arg),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_HOLD;
            ST_HOLD: begin
                // Accepting the result and issuing the next request share a cycle.
                if (bus.out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            out_op_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                ex_a_q <= head_op;
                ex_b_q <= head_arg;
            end
            // Executor output has settled one cycle after EX_A/EX_B were loaded.
            if (state_q == ST_ISSUE) begin
                out_data_q  <= bus.ex_xout;
                out_op_q    <= ex_a_q;
                out_valid_q <= 1'b1;
            end else if (state_q == ST_HOLD && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ex_a      = ex_a_q;
    assign bus.ex_b      = ex_b_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_enum_op_issuer.sv
module tb_enum_op_issuer;
    import enum_op_pkg::*;

    localparam int unsigned NBITS = 8;
    localparam int unsigned DEPTH = 4;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    enum_op_issuer_if #(.NBITS(NBITS)) bus ();

    enum_op_issuer #(
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Executor model standing in for the combinational executor instance.
    assign bus.ex_xout = op_ref(bus.ex_a, bus.ex_b);

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] data;
    } res_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] exp;
    } vec_t;

    res_t sb[$];
    res_t mon_exp;
    res_t hold_prev;
    logic mon_hold = 1'b0;
    int   n_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: accepted requests queue their expected result, handshaken
    // results are compared in order; a result left un-accepted must not move.
    always @(negedge CLK) begin
        if (!RST_N) begin
            mon_hold = 1'b0;
        end else begin
            if (mon_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", 32'(bus.out_data), 32'(hold_prev.data));
                chk("hold_op", 32'(bus.out_op), 32'(hold_prev.op));
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back({bus.in_op, op_ref(bus.in_op, bus.in_arg)});
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    chk("sb_op", 32'(bus.out_op), 32'(mon_exp.op));
                    chk("sb_data", 32'(bus.out_data), 32'(mon_exp.data));
                end
            end
            mon_hold  = bus.out_valid && !bus.out_ready;
            hold_prev = {bus.out_op, bus.out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        int   start, acc, cyc;
        logic need_new;

        vecs[0] = '{8'd17,  8'd0, 8'd18};
        vecs[1] = '{8'd18,  8'd5, 8'd23};
        vecs[2] = '{8'd19,  8'd5, 8'd14};
        vecs[3] = '{8'd20,  8'd3, 8'd60};
        vecs[4] = '{8'd200, 8'd2, 8'd144};
        vecs[5] = '{8'd19,  8'd3, 8'd16};
        vecs[6] = '{8'd0,   8'd7, 8'd0};

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_arg    = '0;
        bus.out_ready = 1'b0;
        RST_N         = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_op", 32'(bus.out_op), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_ex_a", 32'(bus.ex_a), 32'd0);
        chk("rst_ex_b", 32'(bus.ex_b), 32'd0);
        step();
        RST_N = 1'b1;

        // Single ops with fixed latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = vecs[i].op;
            bus.in_arg   = vecs[i].arg;
            @(negedge CLK);
            chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
            step();
            bus.in_valid = 1'b0;
            @(negedge CLK);
            chk("vec_lat0_valid", 32'(bus.out_valid), 32'd0);
            step();
            @(negedge CLK);
            chk("vec_lat1_valid", 32'(bus.out_valid), 32'd0);
            chk("vec_ex_a", 32'(bus.ex_a), 32'(vecs[i].op));
            chk("vec_ex_b", 32'(bus.ex_b), 32'(vecs[i].arg));
            step();
            @(negedge CLK);
            chk("vec_lat2_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_data", 32'(bus.out_data), 32'(vecs[i].exp));
            chk("vec_op", 32'(bus.out_op), 32'(vecs[i].op));
            step();
        end

        // Fill under backpressure: 5 accepted, 6th refused
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 8'd18;
            bus.in_arg   = 8'(10 + i);
            @(negedge CLK);
            chk("fill_in_ready", 32'(bus.in_ready), (i < 5) ? 32'd1 : 32'd0);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_out_data", 32'(bus.out_data), 32'd28);
        chk("full_out_op", 32'(bus.out_op), 32'd18);
        chk("full_sb_size", 32'(sb.size()), 32'd5);
        step();

        // Random backpressure release
        start = n_out;
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("bp_drained", 32'(sb.size()), 32'd0);
        chk("bp_count", 32'(n_out - start), 32'd5);
        repeat (2) step();

        // Streaming across pointer wrap
        start    = n_out;
        acc      = 0;
        cyc      = 0;
        need_new = 1'b1;
        while (acc < int'(3 * DEPTH + 1) && cyc < 300) begin
            if (need_new) begin
                case ($urandom_range(0, 4))
                    0:       bus.in_op = 8'd17;
                    1:       bus.in_op = 8'd18;
                    2:       bus.in_op = 8'd19;
                    3:       bus.in_op = 8'd20;
                    default: bus.in_op = 8'($urandom_range(0, 255));
                endcase
                bus.in_arg = 8'($urandom_range(0, 255));
            end
            bus.in_valid = 1'b1;
            @(negedge CLK);
            need_new = bus.in_ready;
            if (bus.in_ready) acc++;
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("wrap_accepted", 32'(acc), 32'(3 * DEPTH + 1));
        chk("wrap_drained", 32'(sb.size()), 32'd0);
        chk("wrap_count", 32'(n_out - start), 32'(3 * DEPTH + 1));
        repeat (2) step();

        // Reset while holding a result with 3 entries queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 8'd20;
            bus.in_arg   = 8'(2 + i);
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("prerst_out_valid", 32'(bus.out_valid), 32'd1);
        chk("prerst_sb_size", 32'(sb.size()), 32'd4);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data", 32'(bus.out_data), 32'd0);
        chk("arst_out_op", 32'(bus.out_op), 32'd0);
        chk("arst_ex_a", 32'(bus.ex_a), 32'd0);
        chk("arst_ex_b", 32'(bus.ex_b), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        step();
        RST_N = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("postrst_no_stale", 32'(bus.out_valid), 32'd0);
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_op    = 8'd18;
        bus.in_arg   = 8'd1;
        step();
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("postrst_lat0", 32'(bus.out_valid), 32'd0);
        step();
        @(negedge CLK);
        chk("postrst_lat1", 32'(bus.out_valid), 32'd0);
        step();
        @(negedge CLK);
        chk("postrst_valid", 32'(bus.out_valid), 32'd1);
        chk("postrst_data", 32'(bus.out_data), 32'd19);
        chk("postrst_op", 32'(bus.out_op), 32'd18);
        step();
        repeat (2) step();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
